// File: rtl/lifo_word_packer.sv
// Packs a valid/ready byte stream MSB-first into 32-bit words and pushes each word into a LIFO.
// Optional partial-word flush is enabled by defining PACKER_FLUSH_EN.
module lifo_word_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             lifo_full,
  output logic             lifo_wr,
  output logic [31:0]      lifo_data,
  output logic [1:0]       byte_cnt,
  output logic [CNT_W-1:0] push_count
);

  typedef enum logic {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        data_q, data_d;
  logic [CNT_W-1:0]   push_count_q, push_count_d;
  logic               accept;

  assign in_ready   = (state_q == COLLECT);
  assign accept     = in_valid & in_ready;
  assign lifo_wr    = (state_q == PUSH) & ~lifo_full;
  assign lifo_data  = data_q;
  assign byte_cnt   = byte_cnt_q;
  assign push_count = push_count_q;

`ifndef PACKER_FLUSH_EN
  logic flush_unused;
  assign flush_unused = flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      byte_cnt_q   <= 2'd0;
      data_q       <= 32'd0;
      push_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      push_count_q <= push_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    push_count_d = push_count_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          case (byte_cnt_q)
            2'd0:    data_d[31:24] = in_data;
            2'd1:    data_d[23:16] = in_data;
            2'd2:    data_d[15:8]  = in_data;
            default: data_d[7:0]   = in_data;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = PUSH;
          end
        end
`ifdef PACKER_FLUSH_EN
        // Low-order bytes are already zero because the word register clears after each push.
        if (flush && (state_d == COLLECT) && (byte_cnt_d != 2'd0)) begin
          state_d    = PUSH;
          byte_cnt_d = 2'd0;
        end
`endif
      end
      PUSH: begin
        if (!lifo_full) begin
          push_count_d = push_count_q + CNT_W'(1);
          data_d       = 32'd0;
          state_d      = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_lifo_word_packer.sv
// Randomised and directed bench for lifo_word_packer with a queue-based reference model and scoreboard.
// The flush checks follow PACKER_FLUSH_EN exactly as the design does.
module tb_lifo_word_packer;

  localparam int CNT_W = 2;
`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             lifo_full = 1'b0;
  logic             in_ready;
  logic             lifo_wr;
  logic [31:0]      lifo_data;
  logic [1:0]       byte_cnt;
  logic [CNT_W-1:0] push_count;

  int n_checks = 0;
  int n_fail = 0;
  int n_writes = 0;
  bit full_rand = 1'b0;

  // Reference model: pending bytes of the current word, one pending complete word, pushes so far.
  byte unsigned model_bytes[$];
  bit           model_pend = 1'b0;
  logic [31:0]  model_word = 32'd0;
  int           model_pushes = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  lifo_mem[$];

  lifo_word_packer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .lifo_full  (lifo_full),
    .lifo_wr    (lifo_wr),
    .lifo_data  (lifo_data),
    .byte_cnt   (byte_cnt),
    .push_count (push_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input byte unsigned b[$]);
    logic [31:0] w = 32'd0;
    foreach (b[i]) w = w | (32'(b[i]) << (24 - 8 * i));
    return w;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_output({tag, "_lifo_wr"}, 32'(lifo_wr), 32'd0);
    check_output({tag, "_lifo_data"}, lifo_data, 32'd0);
    check_output({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
    check_output({tag, "_push_count"}, 32'(push_count), 32'd0);
  endtask

  // Model: words complete after 4 accepted bytes (or a flush), then leave on the first non-full cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_bytes.delete();
      model_pend   = 1'b0;
      model_word   = 32'd0;
      model_pushes = 0;
      exp_q.delete();
    end else if (model_pend) begin
      if (!lifo_full) begin
        model_pend = 1'b0;
        model_pushes++;
      end
    end else begin
      if (in_valid) model_bytes.push_back(in_data);
      if (model_bytes.size() == 4 || (FLUSH_EN && flush && model_bytes.size() > 0)) begin
        model_word = pack(model_bytes);
        exp_q.push_back(model_word);
        model_bytes.delete();
        model_pend = 1'b1;
      end
    end
  end

  // Monitor: compares visible outputs with the model and pops the scoreboard on every write.
  always @(negedge clk) begin
    check_output("in_ready", 32'(in_ready), 32'(!model_pend));
    check_output("byte_cnt", 32'(byte_cnt), 32'(model_bytes.size()));
    check_output("lifo_data", lifo_data, model_pend ? model_word : pack(model_bytes));
    check_output("lifo_wr", 32'(lifo_wr), 32'(model_pend && !lifo_full));
    check_output("push_count", 32'(push_count), 32'(model_pushes % (1 << CNT_W)));
    if (lifo_wr === 1'b1) begin
      n_writes++;
      lifo_mem.push_back(lifo_data);
      if (exp_q.size() == 0) begin
        check_output("unexpected_write", lifo_data, 32'hxxxxxxxx);
      end else begin
        check_output("pushed_word", lifo_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (full_rand) lifo_full = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) check_output("byte_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] tmp = w;
    for (int i = 0; i < 4; i++) apply_stimulus(tmp[31-8*i -: 8]);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    send_word(32'h80000000);
    idle(3);
    check_output("single_word_count", 32'(push_count), 32'd1);
    check_output("single_word_mem", lifo_mem[$], 32'h80000000);

    send_word(32'h80000000);
    send_word(32'h40000000);
    idle(3);
    check_output("b2b_count", 32'(push_count), 32'd3);
    check_output("lifo_pop_first", lifo_mem.pop_back(), 32'h40000000);

    apply_stimulus(8'hDE);
    apply_stimulus(8'hAD);
    apply_stimulus(8'hBE);
    lifo_full = 1'b1;
    w0 = n_writes;
    apply_stimulus(8'hEF);
    idle(6);
    check_output("full_hold_data", lifo_data, 32'hDEADBEEF);
    check_output("full_hold_ready", 32'(in_ready), 32'd0);
    check_output("full_hold_nowrite", 32'(n_writes - w0), 32'd0);
    lifo_full = 1'b0;
    idle(3);
    check_output("full_release_writes", 32'(n_writes - w0), 32'd1);
    check_output("full_release_mem", lifo_mem[$], 32'hDEADBEEF);

    apply_stimulus(8'hAB);
    apply_stimulus(8'hCD);
    w0 = n_writes;
    pulse_flush();
    idle(3);
`ifdef PACKER_FLUSH_EN
    check_output("flush_writes", 32'(n_writes - w0), 32'd1);
    check_output("flush_word", lifo_mem[$], 32'hABCD0000);
    check_output("flush_byte_cnt", 32'(byte_cnt), 32'd0);
`else
    check_output("flush_ignored_writes", 32'(n_writes - w0), 32'd0);
    check_output("flush_ignored_byte_cnt", 32'(byte_cnt), 32'd2);
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    idle(3);
    check_output("held_partial_word", lifo_mem[$], 32'hABCD1234);
`endif
    w0 = n_writes;
    pulse_flush();
    idle(3);
    check_output("flush_empty_nowrite", 32'(n_writes - w0), 32'd0);

    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    w0 = n_writes;
    do_reset("rst_partial");
    idle(3);
    check_output("rst_partial_nowrite", 32'(n_writes - w0), 32'd0);
    lifo_full = 1'b1;
    send_word(32'hCAFEF00D);
    idle(2);
    do_reset("rst_push");
    lifo_full = 1'b0;
    idle(3);
    check_output("rst_push_nowrite", 32'(n_writes - w0), 32'd0);

    for (int i = 0; i < 5; i++) send_word(32'($urandom));
    idle(3);
    check_output("count_wrap", 32'(push_count), 32'd1);

    full_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) pulse_flush();
      apply_stimulus(8'($urandom));
    end
    full_rand = 1'b0;
    lifo_full = 1'b0;
    for (int t = 0; t < 20 && (model_pend || exp_q.size() != 0); t++) tick();
    check_output("drain_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
